// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and state encoding for the block-organised data memory
package data_memory_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NUM_BLOCKS = 1 << ADDR_W;
  localparam int DEF_LATENCY = 5;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;
endpackage

// File: rtl/data_memory_latency_counter.sv
// mem_latency_counter: loads LATENCY-1 on request acceptance and counts down to a zero flag
module mem_latency_counter #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  logic [CW-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= CW'(LATENCY - 1);
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = (count == '0);
endmodule

// File: rtl/data_memory.sv
// data_memory: 64 x 32-bit block store with modelled access latency behind the cache's busywait handshake
module data_memory #(
  parameter int LATENCY = data_memory_pkg::DEF_LATENCY,
  parameter int ADDR_W = data_memory_pkg::ADDR_W,
  parameter int DATA_W = data_memory_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);
  import data_memory_pkg::*;
  localparam int BLOCKS = 1 << ADDR_W;
  mem_state_t state, state_nx;
  logic [DATA_W-1:0] mem [BLOCKS];
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic lat_write, accept, zero, complete;
  assign accept = (state == IDLE) && (read || write);
  assign complete = (state == BUSY) && zero;
  // gated by reset so an aborted access releases the cache at once
  assign busywait = !reset && (accept || state == BUSY);
  mem_latency_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .dec  (state == BUSY),
    .zero (zero)
  );
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? BUSY : IDLE;
    else if (state == BUSY) state_nx = zero ? DONE : BUSY;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_write <= 1'b0;
    end else if (accept) begin
      lat_addr <= address;
      lat_data <= writedata;
      lat_write <= write;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < BLOCKS; i++) mem[i] <= '0;
    end else if (complete && lat_write) begin
      mem[lat_addr] <= lat_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) readdata <= '0;
    else if (complete && !lat_write) readdata <= mem[lat_addr];
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  localparam int LAT = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [5:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic busywait;
  int tests = 0;
  int fails = 0;

  data_memory dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .busywait (busywait)
  );

  always #5 clk = ~clk;

  task automatic access(input string name, input logic r, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input logic chg = 1'b0,
                        input logic [5:0] a2 = '0, input logic [31:0] d2 = '0);
    int edges;
    @(negedge clk);
    read = r;
    write = w;
    address = a;
    writedata = d;
    #1;
    tests++;
    if (busywait !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_rise: busywait=%b expected 1", name, busywait);
    end
    edges = 0;
    while (busywait === 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (chg && edges == 2) begin
        address = a2;
        writedata = d2;
      end
    end
    tests++;
    if (edges != LAT + 1) begin
      fails++;
      $display("FAIL %s latency: busywait low after %0d edges expected %0d", name, edges, LAT + 1);
    end
    @(negedge clk);
    tests++;
    if (busywait !== 1'b0) begin
      fails++;
      $display("FAIL %s done_hold: busywait=%b expected 0 with request held", name, busywait);
    end
    read = 1'b0;
    write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (busywait !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: busywait=%b expected 0", busywait);
    end
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_readdata: readdata=%h expected 00000000", readdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    access("read10", 1'b1, 1'b0, 6'd10, 32'h0);
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL read10_data: readdata=%h expected 00000000", readdata);
    end
  endtask

  task automatic test_write_read();
    access("write3", 1'b0, 1'b1, 6'd3, 32'hDEADBEEF);
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL write3_keeps_readdata: readdata=%h expected 00000000", readdata);
    end
    access("read3", 1'b1, 1'b0, 6'd3, 32'h0);
    tests++;
    if (readdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read3_data: readdata=%h expected deadbeef", readdata);
    end
  endtask

  task automatic test_boundary();
    access("write63", 1'b0, 1'b1, 6'd63, 32'h11223344);
    access("read0", 1'b1, 1'b0, 6'd0, 32'h0);
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL read0_data: readdata=%h expected 00000000", readdata);
    end
    access("read63", 1'b1, 1'b0, 6'd63, 32'h0);
    tests++;
    if (readdata !== 32'h11223344) begin
      fails++;
      $display("FAIL read63_data: readdata=%h expected 11223344", readdata);
    end
  endtask

  task automatic test_read_write_both();
    access("rw5", 1'b1, 1'b1, 6'd5, 32'hA5A5A5A5);
    tests++;
    if (readdata !== 32'h11223344) begin
      fails++;
      $display("FAIL rw5_keeps_readdata: readdata=%h expected 11223344", readdata);
    end
    access("read5", 1'b1, 1'b0, 6'd5, 32'h0);
    tests++;
    if (readdata !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL read5_data: readdata=%h expected a5a5a5a5", readdata);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    write = 1'b1;
    address = 6'd7;
    writedata = 32'h77777777;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (busywait !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: busywait=%b expected 0", busywait);
    end
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL abort_readdata: readdata=%h expected 00000000", readdata);
    end
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    access("read7", 1'b1, 1'b0, 6'd7, 32'h0);
    tests++;
    if (readdata !== 32'h0) begin
      fails++;
      $display("FAIL read7_data: readdata=%h expected 00000000", readdata);
    end
  endtask

  task automatic test_busy_change();
    access("write2", 1'b0, 1'b1, 6'd2, 32'h22222222);
    access("write1_chg", 1'b0, 1'b1, 6'd1, 32'h11111111, 1'b1, 6'd2, 32'h99999999);
    access("read1", 1'b1, 1'b0, 6'd1, 32'h0);
    tests++;
    if (readdata !== 32'h11111111) begin
      fails++;
      $display("FAIL read1_data: readdata=%h expected 11111111", readdata);
    end
    access("read2", 1'b1, 1'b0, 6'd2, 32'h0);
    tests++;
    if (readdata !== 32'h22222222) begin
      fails++;
      $display("FAIL read2_data: readdata=%h expected 22222222", readdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_boundary();
    test_read_write_both();
    test_reset_abort();
    test_busy_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
